// File: rtl/mem_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_seq_pkg
// Description : State and access-size encodings shared by mem_access_seq.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_seq_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [1:0] SIZE_8  = 2'd0;
    localparam logic [1:0] SIZE_16 = 2'd1;
    localparam logic [1:0] SIZE_24 = 2'd2;
    localparam logic [1:0] SIZE_32 = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mem_access_seq.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_seq
// Description : Splits 1-4 byte core accesses into little-endian byte cycles
//               on the 8-bit memory bus. MEM_SEQ_FAST_WRITE_EN: one-cycle
//               write bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_seq
    import mem_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        write,
    input  logic [1:0]  size,
    input  logic [15:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] bus_address,
    output logic [7:0]  bus_data_out,
    input  logic [7:0]  bus_data_in,
    output logic        bus_enable,
    output logic        bus_write_enable
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        r_write;
    logic [1:0]  r_size;
    logic [15:0] r_base;
    logic [31:0] r_wdata;
    logic [1:0]  r_index;
    logic [31:0] r_rdata;
    logic        w_last;
    logic        w_on_bus;

    assign w_last   = (r_index == r_size);
    assign w_on_bus = (r_state == ADDR) || (r_state == DATA);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (start) w_state_next = ADDR;
`ifdef MEM_SEQ_FAST_WRITE_EN
            ADDR: begin
                if (!r_write)    w_state_next = DATA;
                else if (w_last) w_state_next = DONE;
                else             w_state_next = ADDR;
            end
`else
            ADDR: w_state_next = DATA;
`endif
            DATA: w_state_next = w_last ? DONE : ADDR;
            DONE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_write <= 1'b0;
            r_size  <= SIZE_8;
            r_base  <= 16'd0;
            r_wdata <= 32'd0;
            r_index <= 2'd0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_write <= write;
                        r_size  <= size;
                        r_base  <= address;
                        r_wdata <= wdata;
                        r_index <= 2'd0;
                        if (!write) r_rdata <= 32'd0;
                    end
                end
`ifdef MEM_SEQ_FAST_WRITE_EN
                ADDR: begin
                    if (r_write && !w_last) r_index <= r_index + 2'd1;
                end
`endif
                DATA: begin
                    // Read byte was registered by the bank at the end of ADDR.
                    if (!r_write) r_rdata[{r_index, 3'b000} +: 8] <= bus_data_in;
                    if (!w_last) r_index <= r_index + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Bus signals decode from state and latched request only.
    assign bus_address      = w_on_bus ? (r_base + {14'd0, r_index}) : 16'd0;
    assign bus_data_out     = w_on_bus ? r_wdata[{r_index, 3'b000} +: 8] : 8'd0;
    assign bus_enable       = w_on_bus;
    assign bus_write_enable = (r_state == ADDR) && r_write;
    assign busy             = w_on_bus;
    assign done             = (r_state == DONE);
    assign rdata            = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_seq
// Description : Directed self-checking bench for mem_access_seq with a
//               one-cycle-latency byte memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        write = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [15:0] address = 16'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic [15:0] bus_address;
    logic [7:0]  bus_data_out;
    logic [7:0]  bus_data_in;
    logic        bus_enable;
    logic        bus_write_enable;

    int total = 0;
    int bad = 0;

    logic [7:0]  mem [0:65535];
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = 16'd0;
    logic [7:0]  pl_data = 8'd0;

    logic [15:0] addr_log [0:31];
    logic        en_log [0:31];
    logic        we_log [0:31];
    logic        busy_log [0:31];
    int          done_cyc;
    int          done_cnt;

    mem_access_seq dut (
        .clk(clk), .reset(reset), .start(start), .write(write), .size(size),
        .address(address), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
        .bus_address(bus_address), .bus_data_out(bus_data_out),
        .bus_data_in(bus_data_in), .bus_enable(bus_enable),
        .bus_write_enable(bus_write_enable)
    );

    always #5 clk = ~clk;

    // Synchronous byte memory: write on enable+we, read data one cycle later.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bus_enable && bus_write_enable) mem[bus_address] <= bus_data_out;
        if (bus_enable) bus_data_in <= mem[bus_address];
    end

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic run_req(input logic w, input logic [1:0] sz,
                           input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        write = w; size = sz; address = a; wdata = d; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_cyc = 0; done_cnt = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            addr_log[k] = bus_address; en_log[k] = bus_enable;
            we_log[k] = bus_write_enable; busy_log[k] = busy;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = k;
            end
        end
    endtask

    task automatic test_reset;
        total++; if (rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata: got %h want 00000000", rdata); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if ({bus_address, bus_data_out, bus_enable, bus_write_enable} !== 26'd0) begin
            bad++; $display("FAIL reset_bus: got addr=%h dout=%h en=%b we=%b want all 0",
                            bus_address, bus_data_out, bus_enable, bus_write_enable);
        end
    endtask

    task automatic test_read32;
        preload(16'h0010, 8'h11); preload(16'h0011, 8'h22);
        preload(16'h0012, 8'h33); preload(16'h0013, 8'h44);
        run_req(1'b0, 2'd3, 16'h0010, 32'h0);
        total++; if (rdata !== 32'h44332211) begin bad++; $display("FAIL read32_data: got %h want 44332211", rdata); end
        total++; if (done_cyc != 9) begin bad++; $display("FAIL read32_done_cycle: got %0d want 9", done_cyc); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL read32_done_count: got %0d want 1", done_cnt); end
        for (int b = 0; b < 4; b++) begin
            total++;
            if (addr_log[2*b+1] !== 16'h0010 + 16'(b) || en_log[2*b+1] !== 1'b1 || we_log[2*b+1] !== 1'b0) begin
                bad++; $display("FAIL read32_addr%0d: got %h en=%b we=%b want %h en=1 we=0",
                                b, addr_log[2*b+1], en_log[2*b+1], we_log[2*b+1], 16'h0010 + 16'(b));
            end
        end
        total++; if (busy_log[1] !== 1'b1 || busy_log[9] !== 1'b0) begin
            bad++; $display("FAIL read32_busy: got %b/%b want 1/0", busy_log[1], busy_log[9]);
        end
    endtask

    task automatic test_write16;
        preload(16'hC000, 8'h55); preload(16'hC001, 8'h55); preload(16'hC002, 8'h55);
        run_req(1'b1, 2'd1, 16'hC000, 32'hDEADBEEF);
        total++; if (mem[16'hC000] !== 8'hEF) begin bad++; $display("FAIL write16_b0: got %h want ef", mem[16'hC000]); end
        total++; if (mem[16'hC001] !== 8'hBE) begin bad++; $display("FAIL write16_b1: got %h want be", mem[16'hC001]); end
        total++; if (mem[16'hC002] !== 8'h55) begin bad++; $display("FAIL write16_b2: got %h want 55", mem[16'hC002]); end
        total++; if (rdata !== 32'h44332211) begin bad++; $display("FAIL write16_rdata_hold: got %h want 44332211", rdata); end
`ifdef MEM_SEQ_FAST_WRITE_EN
        total++; if (done_cyc != 3) begin bad++; $display("FAIL write16_done_cycle: got %0d want 3", done_cyc); end
`else
        total++; if (done_cyc != 5) begin bad++; $display("FAIL write16_done_cycle: got %0d want 5", done_cyc); end
        total++; if (we_log[1] !== 1'b1 || we_log[2] !== 1'b0 || we_log[3] !== 1'b1 || addr_log[3] !== 16'hC001) begin
            bad++; $display("FAIL write16_we_pattern: got %b%b%b addr3=%h want 101 addr3=c001",
                            we_log[1], we_log[2], we_log[3], addr_log[3]);
        end
`endif
    endtask

    task automatic test_wrap;
        preload(16'hFFFE, 8'hAA); preload(16'hFFFF, 8'hBB); preload(16'h0000, 8'hCC);
        run_req(1'b0, 2'd2, 16'hFFFE, 32'hFFFF_FFFF);
        total++; if (rdata !== 32'h00CCBBAA) begin bad++; $display("FAIL wrap_data: got %h want 00ccbbaa", rdata); end
        total++; if (addr_log[1] !== 16'hFFFE || addr_log[3] !== 16'hFFFF || addr_log[5] !== 16'h0000) begin
            bad++; $display("FAIL wrap_addr: got %h %h %h want fffe ffff 0000", addr_log[1], addr_log[3], addr_log[5]);
        end
        total++; if (done_cyc != 7) begin bad++; $display("FAIL wrap_done_cycle: got %0d want 7", done_cyc); end
    endtask

    task automatic test_ignore_start;
        logic late_en;
        preload(16'h0300, 8'h5A);
        @(negedge clk);
        write = 1'b0; size = 2'd0; address = 16'h0300; wdata = 32'h0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_cyc = 0; done_cnt = 0; late_en = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            addr_log[k] = bus_address; we_log[k] = bus_write_enable;
            if (k >= 4 && bus_enable) late_en = 1'b1;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = k;
            end
            if (k == 1) begin write = 1'b1; size = 2'd3; address = 16'h0400; wdata = 32'h12345678; start = 1'b1; end
            else if (k == 3) begin write = 1'b0; size = 2'd3; address = 16'h0500; start = 1'b1; end
            else start = 1'b0;
        end
        total++; if (done_cnt != 1 || done_cyc != 3) begin
            bad++; $display("FAIL ignore_done: got count=%0d cycle=%0d want count=1 cycle=3", done_cnt, done_cyc);
        end
        total++; if (late_en !== 1'b0) begin bad++; $display("FAIL ignore_no_new_access: got bus_enable=1 want 0"); end
        total++; if (addr_log[2] !== 16'h0300 || we_log[1] !== 1'b0) begin
            bad++; $display("FAIL ignore_latched: got addr=%h we=%b want 0300 we=0", addr_log[2], we_log[1]);
        end
        total++; if (rdata !== 32'h0000005A) begin bad++; $display("FAIL ignore_rdata: got %h want 0000005a", rdata); end
    endtask

    task automatic test_reset_mid;
        for (int b = 0; b < 4; b++) preload(16'h0200 + 16'(b), 8'h00);
        @(negedge clk);
        write = 1'b1; size = 2'd3; address = 16'h0200; wdata = 32'h04030201; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        total++; if ({rdata, busy, done, bus_address, bus_data_out, bus_enable, bus_write_enable} !== 60'd0) begin
            bad++; $display("FAIL reset_mid_outputs: got rdata=%h busy=%b done=%b addr=%h dout=%h en=%b we=%b want all 0",
                            rdata, busy, done, bus_address, bus_data_out, bus_enable, bus_write_enable);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        total++; if (done_cnt != 0) begin bad++; $display("FAIL reset_mid_no_done: got %0d want 0", done_cnt); end
        total++; if ({mem[16'h0200], mem[16'h0201], mem[16'h0202], mem[16'h0203]} !== 32'h01000000) begin
            bad++; $display("FAIL reset_mid_mem: got %h %h %h %h want 01 00 00 00",
                            mem[16'h0200], mem[16'h0201], mem[16'h0202], mem[16'h0203]);
        end
    endtask

    task automatic test_write32;
        run_req(1'b1, 2'd3, 16'h0100, 32'hA4A3A2A1);
        total++; if ({mem[16'h0100], mem[16'h0101], mem[16'h0102], mem[16'h0103]} !== 32'hA1A2A3A4) begin
            bad++; $display("FAIL write32_mem: got %h %h %h %h want a1 a2 a3 a4",
                            mem[16'h0100], mem[16'h0101], mem[16'h0102], mem[16'h0103]);
        end
`ifdef MEM_SEQ_FAST_WRITE_EN
        for (int b = 0; b < 4; b++) begin
            total++;
            if (we_log[b+1] !== 1'b1 || addr_log[b+1] !== 16'h0100 + 16'(b)) begin
                bad++; $display("FAIL write32_fast_cycle%0d: got we=%b addr=%h want we=1 addr=%h",
                                b + 1, we_log[b+1], addr_log[b+1], 16'h0100 + 16'(b));
            end
        end
        total++; if (done_cyc != 5) begin bad++; $display("FAIL write32_done_cycle: got %0d want 5", done_cyc); end
`else
        for (int k = 1; k <= 8; k++) begin
            total++;
            if (we_log[k] !== ((k % 2) == 1)) begin
                bad++; $display("FAIL write32_we_cycle%0d: got %b want %b", k, we_log[k], (k % 2) == 1);
            end
        end
        total++; if (done_cyc != 9) begin bad++; $display("FAIL write32_done_cycle: got %0d want 9", done_cyc); end
`endif
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        @(negedge clk);
        reset = 1'b0;
        test_read32;
        test_write16;
        test_wrap;
        test_ignore_start;
        test_reset_mid;
        test_write32;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
